// File: rtl/mac_rx_frame.sv
// mac_rx_frame
//   Receive-side MAC framing stage. Strips preamble/SFD from a GMII-style
//   byte stream, accepts only frames addressed to LOCAL_MAC (or broadcast)
//   with EtherType ETH_TYPE, and writes the payload (FCS removed) into the RX
//   byte FIFO. A completed frame is offered to fifo_read through fs/fd.
//
// Ports
//   clk        system clock, everything on posedge
//   rst        synchronous active-low reset
//   rx_dv/rxd  receive data valid / receive byte
//   fifo_full  RX FIFO full
//   fifo_txd   byte written to the FIFO
//   fifo_txen  FIFO write enable, one byte per high cycle
//   fifo_rst   one-cycle FIFO flush when a partially written frame is abandoned
//   fifo_num   payload bytes written for the current frame (stable while fs=1)
//   fs         frame ready request to fifo_read
//   fd         fifo_read done
//   err        one-cycle error pulse
module mac_rx_frame #(
  parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_02_03,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter logic [11:0] MAX_LEN   = 12'd1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rxd,
  input  logic        fifo_full,
  output logic [7:0]  fifo_txd,
  output logic        fifo_txen,
  output logic        fifo_rst,
  output logic [11:0] fifo_num,
  output logic        fs,
  input  logic        fd,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HEAD = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_DROP = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic            mac_loc_q, mac_loc_d;   // dest still matches LOCAL_MAC so far
  logic            mac_bc_q, mac_bc_d;     // dest still matches broadcast so far
  logic [3:0][7:0] dly_q, dly_d;           // dly[3] is the oldest byte
  logic [2:0]      dly_cnt_q, dly_cnt_d;
  logic [11:0]     fifo_num_q, fifo_num_d;
  logic [7:0]      fifo_txd_q, fifo_txd_d;
  logic            fifo_txen_q, fifo_txen_d;
  logic            fifo_rst_q, fifo_rst_d;
  logic            fs_q, fs_d;
  logic            err_q, err_d;

  logic            loc_ok_s;
  logic            bc_ok_s;
  logic            write_due_s;

  // Destination MAC byte for header index 0..5, MSB first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [3:0] idx);
    case (idx)
      4'd0:    return mac[47:40];
      4'd1:    return mac[39:32];
      4'd2:    return mac[31:24];
      4'd3:    return mac[23:16];
      4'd4:    return mac[15:8];
      4'd5:    return mac[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign loc_ok_s    = mac_loc_q && (rxd == mac_byte(LOCAL_MAC, hdr_idx_q));
  assign bc_ok_s     = mac_bc_q && (rxd == 8'hFF);
  // The line already holds 4 bytes, so shifting one in pushes the oldest out.
  assign write_due_s = rx_dv && (dly_cnt_q == 3'd4);

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    mac_loc_d   = mac_loc_q;
    mac_bc_d    = mac_bc_q;
    dly_d       = dly_q;
    dly_cnt_d   = dly_cnt_q;
    fifo_num_d  = fifo_num_q;
    fifo_txd_d  = fifo_txd_q;
    fifo_txen_d = 1'b0;
    fifo_rst_d  = 1'b0;
    fs_d        = fs_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dv && (rxd == 8'h55)) begin
          state_d = S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rxd == 8'h55) begin
          state_d = S_PRE;
        end else if (rxd == 8'hD5) begin
          state_d    = S_HEAD;
          fifo_num_d = 12'd0;
          hdr_idx_d  = 4'd0;
          mac_loc_d  = 1'b1;
          mac_bc_d   = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end

      S_HEAD: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (hdr_idx_q < 4'd6) begin
          mac_loc_d = loc_ok_s;
          mac_bc_d  = bc_ok_s;
          if (!loc_ok_s && !bc_ok_s) begin
            state_d = S_DROP;
          end else begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end else if (hdr_idx_q == 4'd12) begin
          if (rxd == ETH_TYPE[15:8]) begin
            hdr_idx_d = hdr_idx_q + 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end else if (hdr_idx_q == 4'd13) begin
          if (rxd == ETH_TYPE[7:0]) begin
            state_d   = S_DATA;
            dly_cnt_d = 3'd0;
          end else begin
            state_d = S_DROP;
          end
        end else begin
          // Source MAC bytes are not filtered.
          hdr_idx_d = hdr_idx_q + 4'd1;
        end
      end

      S_DATA: begin
        if (write_due_s && (fifo_full || (fifo_num_q == MAX_LEN))) begin
          // Abort takes priority over everything else in this state.
          err_d      = 1'b1;
          fifo_rst_d = 1'b1;
          state_d    = S_DROP;
        end else if (rx_dv) begin
          dly_d = {dly_q[2:0], rxd};
          if (dly_cnt_q != 3'd4) begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end else begin
            dly_cnt_d = dly_cnt_q;
          end
          if (write_due_s) begin
            fifo_txen_d = 1'b1;
            fifo_txd_d  = dly_q[3];
            fifo_num_d  = fifo_num_q + 12'd1;
          end else begin
            fifo_txen_d = 1'b0;
          end
        end else if (fifo_num_q != 12'd0) begin
          // The four bytes still in the line are the FCS and are dropped.
          state_d = S_DONE;
          fs_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end

      S_DONE: begin
        if (fd) begin
          fs_d = 1'b0;
          if (rx_dv) begin
            state_d = S_DROP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          fs_d = 1'b1;
        end
      end

      S_DROP: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end

      default: begin
        state_d = S_IDLE;
        fs_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      hdr_idx_q   <= 4'd0;
      mac_loc_q   <= 1'b0;
      mac_bc_q    <= 1'b0;
      dly_q       <= '0;
      dly_cnt_q   <= 3'd0;
      fifo_num_q  <= 12'd0;
      fifo_txd_q  <= 8'h00;
      fifo_txen_q <= 1'b0;
      fifo_rst_q  <= 1'b0;
      fs_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      mac_loc_q   <= mac_loc_d;
      mac_bc_q    <= mac_bc_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      fifo_num_q  <= fifo_num_d;
      fifo_txd_q  <= fifo_txd_d;
      fifo_txen_q <= fifo_txen_d;
      fifo_rst_q  <= fifo_rst_d;
      fs_q        <= fs_d;
      err_q       <= err_d;
    end
  end

  assign fifo_txd  = fifo_txd_q;
  assign fifo_txen = fifo_txen_q;
  assign fifo_rst  = fifo_rst_q;
  assign fifo_num  = fifo_num_q;
  assign fs        = fs_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mac_rx_frame.sv
// tb_mac_rx_frame
//   Randomized frame stimulus for mac_rx_frame. Each frame's expected FIFO
//   writes are derived from the frame contents and pushed into a scoreboard
//   queue; a negedge monitor pops and compares every fifo_txen byte.
module tb_mac_rx_frame;

  localparam logic [47:0] LOCAL = 48'h00_0A_35_01_02_03;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ETH   = 16'h88B5;
  localparam int          MAXL  = 1500;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        fifo_full = 1'b0;
  logic        fd = 1'b0;
  logic [7:0]  fifo_txd;
  logic        fifo_txen;
  logic        fifo_rst;
  logic [11:0] fifo_num;
  logic        fs;
  logic        err;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int   err_seen = 0;
  int   frst_seen = 0;
  logic rst_edge = 1'b0;

  always #5 clk = ~clk;

  mac_rx_frame dut (
    .clk(clk), .rst(rst), .rx_dv(rx_dv), .rxd(rxd), .fifo_full(fifo_full),
    .fifo_txd(fifo_txd), .fifo_txen(fifo_txen), .fifo_rst(fifo_rst),
    .fifo_num(fifo_num), .fs(fs), .fd(fd), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rst_edge <= rst;

  // Scoreboard monitor: compares every FIFO write against the expected queue.
  always @(negedge clk) begin
    if (!rst_edge) begin
      check("txen_after_reset", {31'd0, fifo_txen}, 32'd0);
    end else begin
      if (err) err_seen++;
      if (fifo_rst) frst_seen++;
      if (fifo_txen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %02h expected no write", fifo_txd);
        end else begin
          check("write_data", {24'd0, fifo_txd}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc(input logic dv, input logic [7:0] d, input logic full,
                     input logic r, input logic f);
    rx_dv = dv; rxd = d; fifo_full = full; rst = r; fd = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_txen"}, {31'd0, fifo_txen}, 32'd0);
    check({tag, "_frst"}, {31'd0, fifo_rst}, 32'd0);
    check({tag, "_err"},  {31'd0, err}, 32'd0);
    check({tag, "_fs"},   {31'd0, fs}, 32'd0);
    check({tag, "_txd"},  {24'd0, fifo_txd}, 32'd0);
    check({tag, "_num"},  {20'd0, fifo_num}, 32'd0);
  endtask

  // Sends one frame and checks it. cut>=0 ends rx_dv after that many header
  // bytes; full_at>=0 raises fifo_full when payload byte full_at is due;
  // rst_at>=0 pulses reset while payload byte rst_at is on the wire.
  task automatic run_frame(input logic [47:0] dest, input logic [15:0] etype,
                           input int plen, input int npre, input int cut,
                           input int full_at, input int rst_at, input bit rnd,
                           input bit busy, input bit do_fd);
    logic [7:0] fb[$];
    logic [7:0] pl[$];
    int hdr_start, data_start, total, hcut, k, ab, nwr;
    bit dest_ok, type_ok, exp_err, exp_frst, exp_fs, full, r;
    for (int i = 0; i < npre; i++) fb.push_back(8'h55);
    fb.push_back(8'hD5);
    hdr_start = fb.size();
    for (int i = 0; i < 6; i++) fb.push_back(dest[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
    fb.push_back(etype[15:8]);
    fb.push_back(etype[7:0]);
    data_start = fb.size();
    for (int i = 0; i < plen; i++) begin
      if (rst_at >= 0 && i > rst_at) pl.push_back(8'hAA);
      else if (rnd) pl.push_back(8'($urandom));
      else pl.push_back(8'(i));
    end
    foreach (pl[i]) fb.push_back(pl[i]);
    for (int i = 0; i < 4; i++) fb.push_back(rst_at >= 0 ? 8'hAA : 8'($urandom));

    // Reference outcome from the frame's fields.
    hcut = (cut < 0) ? 14 : cut;
    k = (hcut < 6) ? hcut : 6;
    dest_ok = (k == 0) || (((dest ^ LOCAL) >> (8*(6-k))) == 48'd0)
                       || (((dest ^ BCAST) >> (8*(6-k))) == 48'd0);
    type_ok = (hcut < 13 || etype[15:8] == ETH[15:8]) && (hcut < 14 || etype[7:0] == ETH[7:0]);
    exp_err = 0; exp_frst = 0; exp_fs = 0; nwr = 0;
    if (busy) begin
      exp_fs = 1;
    end else if (!dest_ok || !type_ok) begin
      nwr = 0;
    end else if (hcut < 14) begin
      exp_err = 1;
    end else if (rst_at >= 0) begin
      nwr = (rst_at > 4) ? rst_at - 4 : 0;
    end else begin
      ab = plen;
      if (full_at >= 0 && full_at < ab) ab = full_at;
      if (plen > MAXL && MAXL < ab) ab = MAXL;
      nwr = ab;
      if (ab < plen) begin exp_err = 1; exp_frst = 1; end
      else if (plen == 0) exp_err = 1;
      else exp_fs = 1;
    end
    for (int i = 0; i < nwr; i++) exp_q.push_back(pl[i]);

    err_seen = 0;
    frst_seen = 0;
    total = (cut >= 0) ? hdr_start + cut : fb.size();
    for (int i = 0; i < total; i++) begin
      full = (full_at >= 0) && (i == data_start + full_at + 4);
      r = !((rst_at >= 0) && (i == data_start + rst_at));
      cyc(1'b1, fb[i], full, r, 1'b0);
      if (!r) check_cleared("mid_reset");
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    check("writes_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    check("err_pulses", err_seen, {31'd0, exp_err});
    check("fifo_rst_pulses", frst_seen, {31'd0, exp_frst});
    check("fs_level", {31'd0, fs}, {31'd0, exp_fs});
    if (exp_fs && !busy) check("fifo_num", {20'd0, fifo_num}, plen);
    if (exp_fs && do_fd) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      check("fs_after_fd", {31'd0, fs}, 32'd0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] d;
    logic [15:0] t;
    int pl, ct, fa;
    #1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    check_cleared("reset");
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Good frame, payload 00..0B.
    run_frame(LOCAL, ETH, 12, 7, -1, -1, -1, 0, 0, 1);
    // Wrong destination, then a good frame.
    run_frame(48'h00_0A_35_01_02_04, ETH, 12, 7, -1, -1, -1, 0, 0, 1);
    run_frame(LOCAL, ETH, 12, 7, -1, -1, -1, 1, 0, 1);
    // Broadcast, then wrong EtherType.
    run_frame(BCAST, ETH, 20, 7, -1, -1, -1, 1, 0, 1);
    run_frame(BCAST, 16'h0800, 20, 7, -1, -1, -1, 1, 0, 1);
    // rx_dv drops after header byte 5.
    run_frame(LOCAL, ETH, 12, 7, 6, -1, -1, 0, 0, 1);
    // FIFO full when payload byte 3 is due.
    run_frame(LOCAL, ETH, 12, 7, -1, 3, -1, 0, 0, 1);
    // Reset mid-payload, then a good frame counted from zero.
    run_frame(LOCAL, ETH, 16, 7, -1, -1, 8, 0, 0, 1);
    run_frame(LOCAL, ETH, 9, 7, -1, -1, -1, 1, 0, 1);
    // Payload+FCS of only 4 bytes, and the smallest writable payload.
    run_frame(LOCAL, ETH, 0, 7, -1, -1, -1, 1, 0, 1);
    run_frame(LOCAL, ETH, 1, 3, -1, -1, -1, 1, 0, 1);
    // Frame arriving while the previous one waits in DONE is lost.
    run_frame(LOCAL, ETH, 5, 7, -1, -1, -1, 1, 0, 0);
    run_frame(LOCAL, ETH, 8, 7, -1, -1, -1, 1, 1, 0);
    check("num_frozen", {20'd0, fifo_num}, 32'd5);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("fs_after_busy_fd", {31'd0, fs}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    // Length limit: exactly MAX_LEN, then one byte over.
    run_frame(LOCAL, ETH, MAXL, 7, -1, -1, -1, 1, 0, 1);
    run_frame(LOCAL, ETH, MAXL + 1, 7, -1, -1, -1, 1, 0, 1);

    // Randomized frames.
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 3))
        0: d = BCAST;
        1: d = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        default: d = LOCAL;
      endcase
      t  = ($urandom_range(0, 4) == 0) ? 16'(($urandom)) : ETH;
      pl = $urandom_range(0, 40);
      ct = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 13) : -1;
      fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, pl) : -1;
      run_frame(d, t, pl, $urandom_range(1, 7), ct, fa, -1, 1, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
